jump_sequencer: RTL and testbench
=================================

Name: jump_sequencer

Overview:
Game-logic controller that drives the character sprite block. It accepts left/right key pulses, checks the next platform row for a block in the target column, and issues exactly one jump_left/jump_right/jump_fail pulse. It then waits for the character's landed pulse and advances the row/score, or ends the game. It sits between the keyboard decoder, the platform generator and the character block.

Parameters:
COLS, 5, number of platform columns; character starts in column COLS/2
COL_W, 3, width of column index (must hold COLS-1)
SCORE_W, 14, score counter width
LAND_TIMEOUT_MS, 300, max one_ms_tick count waiting for landed before fault

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
module_en  in  1  game-running enable; low acts as synchronous reinit (same as rst)
key_left  in  1  single-cycle left request
key_right  in  1  single-cycle right request
one_ms_tick  in  1  single-cycle 1 ms strobe
landed  in  1  single-cycle pulse from character block: motion finished
next_row_blocks  in  COLS  bit i = platform present in column i of the next row
jump_left  out  1  single-cycle command to character block
jump_right  out  1  single-cycle command to character block
jump_fail  out  1  single-cycle command: fall animation
row_advance  out  1  single-cycle pulse to platform generator: shift rows
char_col  out  COL_W  current column of character
score  out  SCORE_W  successful jumps, saturating
game_over  out  1  level, set after fall landing or timeout
timeout_err  out  1  level, set only on landed timeout

Behaviour:
- Reset / module_en=0: state S_READY, char_col=COLS/2, score=0, all pulses 0, game_over=0, timeout_err=0, pending buffer empty, timer=0.
- All outputs registered; one-cycle latency from decision to pulse.
- Request decode: left = key_left & ~key_right, right = key_right & ~key_left; both high in the same cycle = no request.
- S_READY, request or pending buffer valid (buffer takes priority, then clears):
  - target = char_col-1 (left) or char_col+1 (right).
  - Wall check: left at col 0 or right at col COLS-1 → request dropped, stay S_READY, no pulse.
  - next_row_blocks[target]=1 → pulse jump_left/jump_right, latch target, go S_JUMP.
  - next_row_blocks[target]=0 → pulse jump_fail, go S_FALL.
- S_JUMP: timer counts one_ms_tick. On landed: char_col<=target, score+1 (saturates at all-ones), row_advance pulses the next cycle, go S_READY.
- S_FALL: timer counts ticks. On landed: game_over<=1, go S_OVER.
- One-deep pending buffer: the first valid request during S_JUMP is stored. Later requests are dropped until the buffer is consumed. The buffer is cleared on entering S_FALL or S_OVER.
- Timeout: in S_JUMP/S_FALL, if the timer reaches LAND_TIMEOUT_MS with no landed → game_over=1, timeout_err=1, S_OVER. landed in the same cycle as the timeout → landed wins.
- Timer resets to 0 on every entry to S_JUMP/S_FALL.
- S_OVER: all inputs ignored; leaves only via rst or module_en=0.
- landed in S_READY/S_OVER: ignored.
- rst mid-jump: immediate return to reset values; no pulses emitted that cycle.

Decomposition:
- Shared package/macros header: state encodings (S_READY, S_JUMP, S_FALL, S_OVER), default COLS and SCORE_W, alongside the existing GAME_WIDTH/VGA bus macros.
- One sub-module: land_timer (tick counter with clear, enable and terminal-count flag).
- Remaining logic stays in one FSM module.

Test Plan:
- Reset, next_row_blocks=5'b01000, key_right pulse → jump_right high exactly 1 cycle, 1 cycle later; landed → char_col=3, score=1, row_advance 1-cycle pulse.
- char_col=2, next_row_blocks=5'b00100, key_left → jump_fail pulse; landed → game_over=1, timeout_err=0; subsequent keys produce no pulses.
- Move to col 0 via successful jumps, key_left → no output pulse, state unchanged; key_left+key_right in the same cycle → no pulse.
- Key_right during S_JUMP, then landed, valid block at new target → second jump_right issued 1 cycle after returning to S_READY; a third key during the same jump is dropped.
- S_JUMP with no landed for 300 one_ms_ticks → game_over=1, timeout_err=1; landed coincident with tick 300 → normal landing instead.
- score preloaded near max (SCORE_W=2 build), 4 successful jumps → score stays 3; module_en low mid-jump → char_col=2, score=0 on the next cycle.

Source files
------------

// File: rtl/jump_sequencer_pkg.sv
// Shared definitions for the jump game logic: display bus sizes, default
// playfield geometry and the sequencer state encoding.
package jump_sequencer_pkg;

  // Display geometry and VGA colour bus width used across the game blocks.
  localparam int GAME_WIDTH  = 640;
  localparam int GAME_HEIGHT = 480;
  localparam int VGA_RGB_W   = 12;

  // Default playfield and scoring parameters.
  localparam int DEF_COLS            = 5;
  localparam int DEF_COL_W           = 3;
  localparam int DEF_SCORE_W         = 14;
  localparam int DEF_LAND_TIMEOUT_MS = 300;

  // Sequencer states: waiting for a key, jumping onto a block,
  // falling into a gap, and game finished.
  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_JUMP  = 2'd1,
    S_FALL  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/jump_sequencer_land_timer.sv
// Counts 1 ms ticks while the character is in the air. The expire flag is
// raised combinationally in the cycle whose tick brings the count to LIMIT,
// so a landed pulse in that same cycle can still take priority upstream.
module land_timer #(
  parameter int LIMIT = 300,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // Tick counter: cleared while idle, advances on enabled ticks, holds at LIMIT.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && tick && (count != CNT_W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && tick && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/jump_sequencer.sv
// Game-logic controller between the keyboard decoder, the platform
// generator and the character block. Turns left/right key pulses into a
// single jump or fall command, waits for the character to land, then
// advances the row and score or ends the game.
//
// Handshake: every command/strobe in and out is a single-cycle pulse with
// no back-pressure; a pulse is acted on in the cycle it is high and each
// registered output pulse is high for exactly one cycle.
module jump_sequencer
  import jump_sequencer_pkg::*;
#(
  parameter int COLS            = DEF_COLS,
  parameter int COL_W           = DEF_COL_W,
  parameter int SCORE_W         = DEF_SCORE_W,
  parameter int LAND_TIMEOUT_MS = DEF_LAND_TIMEOUT_MS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               module_en,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               one_ms_tick,
  input  logic               landed,
  input  logic [COLS-1:0]    next_row_blocks,
  output logic               jump_left,
  output logic               jump_right,
  output logic               jump_fail,
  output logic               row_advance,
  output logic [COL_W-1:0]   char_col,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               timeout_err,
  output state_t             dbg_state
);

  localparam logic [COL_W-1:0] START_COL = COL_W'(COLS / 2);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);

  // Dropping module_en restarts the game exactly like rst.
  logic reinit;
  assign reinit = rst | ~module_en;

  state_t state, state_next;

  logic req_left, req_right, req_valid;
  logic use_valid, use_right, at_wall, hit;
  logic [COL_W-1:0] target_col, target_q, target_n;

  logic pend_valid, pend_right, pend_valid_n, pend_right_n;

  logic jump_left_n, jump_right_n, jump_fail_n, row_advance_n;
  logic [COL_W-1:0]   char_col_n;
  logic [SCORE_W-1:0] score_n;
  logic game_over_n, timeout_err_n;

  logic timer_clear, timer_enable, timer_expire;

  assign dbg_state = state;

  // Decode keys and pick the request to act on; a buffered request beats a live one.
  always_comb begin
    req_left   = key_left & ~key_right;
    req_right  = key_right & ~key_left;
    req_valid  = req_left | req_right;
    use_valid  = pend_valid | req_valid;
    use_right  = pend_valid ? pend_right : req_right;
    target_col = use_right ? (char_col + 1'b1) : (char_col - 1'b1);
    at_wall    = use_right ? (char_col == LAST_COL) : (char_col == '0);
    hit        = next_row_blocks[target_col];
  end

  // Timer runs only in the air and is zeroed while waiting, so every jump starts fresh.
  assign timer_clear  = reinit | (state == S_READY) | (state == S_OVER);
  assign timer_enable = (state == S_JUMP) | (state == S_FALL);

  land_timer #(
    .LIMIT (LAND_TIMEOUT_MS)
  ) u_land_timer (
    .clk    (clk),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tick   (one_ms_tick),
    .expire (timer_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reinit) begin
      state <= S_READY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a landing in the timeout cycle counts as a normal landing.
  always_comb begin
    state_next = state;
    case (state)
      S_READY: begin
        if (use_valid && !at_wall) begin
          state_next = hit ? S_JUMP : S_FALL;
        end
      end
      S_JUMP: begin
        if (landed) begin
          state_next = S_READY;
        end else if (timer_expire) begin
          state_next = S_OVER;
        end
      end
      S_FALL: begin
        if (landed || timer_expire) begin
          state_next = S_OVER;
        end
      end
      default: state_next = state;
    endcase
  end

  // Output and datapath next values, registered below for one-cycle latency.
  always_comb begin
    jump_left_n   = 1'b0;
    jump_right_n  = 1'b0;
    jump_fail_n   = 1'b0;
    row_advance_n = 1'b0;
    char_col_n    = char_col;
    score_n       = score;
    game_over_n   = game_over;
    timeout_err_n = timeout_err;
    target_n      = target_q;
    pend_valid_n  = pend_valid;
    pend_right_n  = pend_right;
    case (state)
      S_READY: begin
        // Any buffered request is consumed here, even if the wall drops it.
        pend_valid_n = 1'b0;
        if (use_valid && !at_wall) begin
          if (hit) begin
            jump_left_n  = ~use_right;
            jump_right_n = use_right;
            target_n     = target_col;
          end else begin
            jump_fail_n = 1'b1;
          end
        end
      end
      S_JUMP: begin
        if (req_valid && !pend_valid) begin
          pend_valid_n = 1'b1;
          pend_right_n = req_right;
        end
        if (landed) begin
          char_col_n    = target_q;
          row_advance_n = 1'b1;
          if (score != '1) begin
            score_n = score + 1'b1;
          end
        end else if (timer_expire) begin
          game_over_n   = 1'b1;
          timeout_err_n = 1'b1;
          pend_valid_n  = 1'b0;
        end
      end
      S_FALL: begin
        if (landed) begin
          game_over_n = 1'b1;
        end else if (timer_expire) begin
          game_over_n   = 1'b1;
          timeout_err_n = 1'b1;
        end
      end
      default: begin
        pend_valid_n = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reinit wins over any decision in the same cycle.
  always_ff @(posedge clk) begin
    if (reinit) begin
      jump_left   <= 1'b0;
      jump_right  <= 1'b0;
      jump_fail   <= 1'b0;
      row_advance <= 1'b0;
      char_col    <= START_COL;
      score       <= '0;
      game_over   <= 1'b0;
      timeout_err <= 1'b0;
      target_q    <= START_COL;
      pend_valid  <= 1'b0;
      pend_right  <= 1'b0;
    end else begin
      jump_left   <= jump_left_n;
      jump_right  <= jump_right_n;
      jump_fail   <= jump_fail_n;
      row_advance <= row_advance_n;
      char_col    <= char_col_n;
      score       <= score_n;
      game_over   <= game_over_n;
      timeout_err <= timeout_err_n;
      target_q    <= target_n;
      pend_valid  <= pend_valid_n;
      pend_right  <= pend_right_n;
    end
  end

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: directed scenarios followed by random play,
// checked against a game-rule model and an expected-event queue.
module tb_jump_sequencer;

  localparam int COLS  = 5;
  localparam int COL_W = 3;
  localparam int SW    = 3;
  localparam int TMO   = 300;

  // Event codes: {jump_left, jump_right, jump_fail, row_advance, game_over rise}
  localparam logic [4:0] EV_JL = 5'b10000;
  localparam logic [4:0] EV_JR = 5'b01000;
  localparam logic [4:0] EV_JF = 5'b00100;
  localparam logic [4:0] EV_RA = 5'b00010;
  localparam logic [4:0] EV_GO = 5'b00001;

  // Model phases
  localparam int P_READY = 0;
  localparam int P_UP    = 1;
  localparam int P_DOWN  = 2;
  localparam int P_DEAD  = 3;

  logic clk = 1'b0;
  logic rst, module_en, key_left, key_right, one_ms_tick, landed;
  logic [COLS-1:0] next_row_blocks;
  logic jump_left, jump_right, jump_fail, row_advance, game_over, timeout_err;
  logic [COL_W-1:0] char_col;
  logic [SW-1:0] score;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  // Reference model of the game
  int m_phase, m_col, m_score, m_tgt, m_ticks;
  bit m_go, m_te, m_pend, m_pend_right;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  jump_sequencer #(
    .COLS(COLS), .COL_W(COL_W), .SCORE_W(SW), .LAND_TIMEOUT_MS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en),
    .key_left(key_left), .key_right(key_right),
    .one_ms_tick(one_ms_tick), .landed(landed),
    .next_row_blocks(next_row_blocks),
    .jump_left(jump_left), .jump_right(jump_right), .jump_fail(jump_fail),
    .row_advance(row_advance), .char_col(char_col), .score(score),
    .game_over(game_over), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the game rules to one clock of inputs.
  task automatic model_step(input bit kl, input bit kr, input bit ld, input bit tk,
                            input logic [COLS-1:0] bl, input bit r, input bit en);
    bit want, right;
    int dest;
    if (r || !en) begin
      m_phase = P_READY; m_col = COLS / 2; m_score = 0; m_tgt = 0;
      m_ticks = 0; m_go = 0; m_te = 0; m_pend = 0; m_pend_right = 0;
      return;
    end
    want  = kl ^ kr;
    right = kr;
    case (m_phase)
      P_READY: begin
        if (m_pend) begin
          want  = 1;
          right = m_pend_right;
          m_pend = 0;
        end
        if (want) begin
          dest = right ? m_col + 1 : m_col - 1;
          if (dest >= 0 && dest < COLS) begin
            m_ticks = 0;
            if (bl[dest]) begin
              exp_q.push_back(right ? EV_JR : EV_JL);
              m_tgt = dest;
              m_phase = P_UP;
            end else begin
              exp_q.push_back(EV_JF);
              m_phase = P_DOWN;
            end
          end
        end
      end
      P_UP, P_DOWN: begin
        if (m_phase == P_UP && want && !m_pend) begin
          m_pend = 1;
          m_pend_right = right;
        end
        if (ld) begin
          if (m_phase == P_UP) begin
            m_col = m_tgt;
            if (m_score < (1 << SW) - 1) m_score++;
            exp_q.push_back(EV_RA);
            m_phase = P_READY;
          end else begin
            m_go = 1;
            exp_q.push_back(EV_GO);
            m_phase = P_DEAD;
          end
        end else if (tk) begin
          m_ticks++;
          if (m_ticks == TMO) begin
            m_go = 1; m_te = 1; m_pend = 0;
            exp_q.push_back(EV_GO);
            m_phase = P_DEAD;
          end
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit kl, input bit kr, input bit ld, input bit tk,
                       input logic [COLS-1:0] bl, input bit r = 1'b0, input bit en = 1'b1);
    key_left = kl; key_right = kr; landed = ld; one_ms_tick = tk;
    next_row_blocks = bl; rst = r; module_en = en;
    model_step(kl, kr, ld, tk, bl, r, en);
    @(posedge clk);
    #1;
    check("char_col", int'(char_col), m_col);
    check("score", int'(score), m_score);
    check("game_over", int'(game_over), int'(m_go));
    check("timeout_err", int'(timeout_err), int'(m_te));
    key_left = 0; key_right = 0; landed = 0; one_ms_tick = 0; rst = 0; module_en = 1;
  endtask

  task automatic idle(input int n, input logic [COLS-1:0] bl);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, bl);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, '0, 1'b1);
    cycle(0, 0, 0, 0, '0, 1'b1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_go = 1'b0;
  always @(negedge clk) begin
    logic [4:0] ev;
    ev = {jump_left, jump_right, jump_fail, row_advance, game_over & ~prev_go};
    prev_go = game_over;
    if (ev != 5'b0) begin
      if (exp_q.size() == 0) check("unexpected_event", int'(ev), 0);
      else check("event", int'(ev), int'(exp_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; module_en = 1; key_left = 0; key_right = 0;
    one_ms_tick = 0; landed = 0; next_row_blocks = '0;

    // Reset state
    do_reset();
    check("reset_col", int'(char_col), 2);
    check("reset_score", int'(score), 0);
    check("reset_pulses", int'({jump_left, jump_right, jump_fail, row_advance}), 0);
    check("reset_state", int'(dbg_state), 0);

    // Successful right jump
    cycle(0, 1, 0, 0, 5'b01000);
    check("t1_jr_now", int'(jump_right), 1);
    idle(1, 5'b01000);
    check("t1_jr_gone", int'(jump_right), 0);
    idle(2, 5'b01000);
    cycle(0, 0, 1, 0, 5'b01000);
    check("t1_col", int'(char_col), 3);
    check("t1_score", int'(score), 1);
    check("t1_ra_now", int'(row_advance), 1);
    idle(1, 5'b01000);
    check("t1_ra_gone", int'(row_advance), 0);

    // Jump into a gap, fall, game over; later keys ignored
    do_reset();
    cycle(1, 0, 0, 0, 5'b00100);
    check("t2_jf", int'(jump_fail), 1);
    idle(3, 5'b00100);
    cycle(0, 0, 1, 0, 5'b00100);
    check("t2_go", int'(game_over), 1);
    check("t2_te", int'(timeout_err), 0);
    cycle(1, 0, 0, 0, 5'b11111);
    cycle(0, 1, 0, 0, 5'b11111);
    cycle(0, 0, 1, 1, 5'b11111);
    idle(2, 5'b11111);

    // Walk to column 0, wall and double-key requests produce nothing
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 0, 5'b11111);
      idle(1, 5'b11111);
      cycle(0, 0, 1, 0, 5'b11111);
    end
    check("t3_col0", int'(char_col), 0);
    cycle(1, 0, 0, 0, 5'b11111);
    cycle(1, 1, 0, 0, 5'b11111);
    idle(2, 5'b11111);
    check("t3_idle_state", int'(dbg_state), 0);

    // Pending buffer: second right is stored, third key dropped
    do_reset();
    cycle(0, 1, 0, 0, 5'b11111);
    cycle(0, 1, 0, 0, 5'b11111);
    cycle(1, 0, 0, 0, 5'b11111);
    cycle(0, 0, 1, 0, 5'b11111);
    check("t4_ra", int'(row_advance), 1);
    cycle(0, 0, 0, 0, 5'b11111);
    check("t4_jr2", int'(jump_right), 1);
    idle(2, 5'b11111);
    cycle(0, 0, 1, 0, 5'b11111);
    check("t4_col", int'(char_col), 4);
    idle(3, 5'b11111);

    // Landing timeout while jumping
    do_reset();
    cycle(0, 1, 0, 0, 5'b11111);
    for (int i = 0; i < TMO; i++) cycle(0, 0, 0, 1, 5'b11111);
    check("t5_go", int'(game_over), 1);
    check("t5_te", int'(timeout_err), 1);

    // Landing on the same cycle as the final tick wins
    do_reset();
    cycle(0, 1, 0, 0, 5'b11111);
    for (int i = 0; i < TMO - 1; i++) cycle(0, 0, 0, 1, 5'b11111);
    cycle(0, 0, 1, 1, 5'b11111);
    check("t5b_go", int'(game_over), 0);
    check("t5b_col", int'(char_col), 3);

    // Timer restarts for each jump
    do_reset();
    for (int j = 0; j < 2; j++) begin
      cycle(j == 0, j == 1, 0, 0, 5'b11111);
      for (int i = 0; i < 200; i++) cycle(0, 0, 0, 1, 5'b11111);
      cycle(0, 0, 1, 0, 5'b11111);
    end
    check("t5c_te", int'(timeout_err), 0);

    // Timeout while falling
    do_reset();
    cycle(0, 1, 0, 0, 5'b00000);
    for (int i = 0; i < TMO; i++) cycle(0, 0, 0, 1, 5'b00000);
    check("t5d_te", int'(timeout_err), 1);

    // Score saturation
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(i % 2 == 1, i % 2 == 0, 0, 0, 5'b11111);
      cycle(0, 0, 1, 0, 5'b11111);
    end
    check("t6_sat", int'(score), 7);

    // module_en low mid-jump
    cycle(0, 1, 0, 0, 5'b11111);
    cycle(0, 0, 1, 0, 5'b11111, 1'b0, 1'b0);
    check("t6_en_col", int'(char_col), 2);
    check("t6_en_score", int'(score), 0);
    idle(2, 5'b11111);

    // Random play
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = (m_phase == P_DEAD && $urandom_range(0, 15) == 0) || ($urandom_range(0, 399) == 0);
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            COLS'($urandom_range(0, (1 << COLS) - 1)),
            r, $urandom_range(0, 399) != 0);
    end

    idle(4, '0);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
